memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Memory stage of the 5-stage RV32I pipeline. Consumes execute-stage outputs and holds the EX/MEM pipeline register.
- Performs byte, halfword and word loads/stores over a req/ready data-memory handshake, then registers results into the MEM/WB register.
- Drives the EX/MEM forwarding bus back to execute.
- Stalls upstream while a memory access is outstanding.

Parameters:
ADDR_W, 32, byte-address width of mem_addr
FAULT_SUPPRESS, 1, when 1 a faulting op forces out_RegWrite=0 and issues no request

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_MemRead  in  1  load
in_MemWrite  in  1  store
in_RegWrite  in  1  writes rd
in_RegDest  in  5  rd
in_MemToReg  in  1  WB selects load data
in_Funct3  in  3  access size/sign (RV32I load/store funct3)
in_AluResult  in  32  effective address or ALU result
in_rs2_value  in  32  store data
stall  out  1  hold all upstream stages and inputs
mem_req  out  1  access request
mem_we  out  1  1=store
mem_addr  out  ADDR_W  word-aligned address {addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte enables
mem_ready  in  1  access completes this cycle
mem_rdata  in  32  aligned read word, valid when mem_ready=1
ex_mem_RegWrite  out  1  forwarding: latched RegWrite
ex_mem_RegDest  out  5  forwarding: latched rd
ex_mem_result  out  32  forwarding: latched AluResult
out_RegWrite  out  1  MEM/WB
out_RegDest  out  5  MEM/WB
out_MemToReg  out  1  MEM/WB
out_AluResult  out  32  MEM/WB
out_data  out  32  MEM/WB extended load data
out_fault  out  1  one-cycle pulse: misaligned or illegal funct3

Behaviour:
- Reset: every output 0; state IDLE; EX/MEM latch cleared; mem_req=0. A reset during ACCESS abandons the request, so mem_req is 0 in the cycle after the reset edge.
- EX/MEM latch: loads all in_* on each edge where stall=0. All-zero control is a bubble and passes through.
- Fault is evaluated on latched values:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - funct3 not one of 000/001/010/100/101 for loads, or 000/001/010 for stores.
- A mem op with fault, or a non-mem op, enters IDLE. A non-faulting mem op enters ACCESS.
- FSM:
  - IDLE: mem_req=0, stall=0.
  - ACCESS: mem_req=1, mem_we=latched MemWrite, stall=!mem_ready.
  - ACCESS leaves at the edge where mem_ready=1. The next state is set by the newly latched op.
  - Single-cycle access is possible: mem_req asserted and mem_ready=1 in the same cycle gives zero stall.
- mem_addr, mem_wdata and mem_wstrb are stable for the whole of ACCESS.
- Store lanes (o=addr[1:0]):
  - SB: strb=0001<<o, wdata={4{rs2[7:0]}}.
  - SH: strb=0011<<o, wdata={2{rs2[15:0]}}.
  - SW: strb=1111, wdata=rs2.
- Load extract:
  - LB/LBU: byte o, sign- or zero-extended.
  - LH/LHU: half o[1], sign- or zero-extended.
  - LW: full word.
- MEM/WB register updates at every edge where stall=0:
  - out_RegWrite = latched RegWrite & !(fault & FAULT_SUPPRESS).
  - out_data = extracted load when the latched op is a load, else 0.
  - out_fault = fault.
  - Remaining fields are copied from the latch.
- Latency: 2 edges from input to MEM/WB for non-mem ops and zero-wait accesses. N wait cycles add N.
- Forwarding bus: combinational from the latch; valid while stalled.
- Upstream must hold in_* while stall=1. The block ignores in_* changes while stalled.

Test Plan:
- ALU op RegWrite=1, rd=5, AluResult=0x1234 -> ex_mem_RegDest=5, ex_mem_result=0x1234 after edge 1; out_RegWrite=1, out_AluResult=0x1234 after edge 2; mem_req never asserted.
- SB addr=0x1003, rs2=0xAABBCCDD, mem_ready=1 -> mem_addr=0x1000, wstrb=1000, wdata=0xDDDDDDDD, mem_we=1, stall=0.
- LB addr=0x2001, mem_rdata=0x0000_80FF, mem_ready low 3 cycles -> stall=1 for exactly 3 cycles; then out_data=0xFFFFFF80, out_MemToReg=1. LBU on the same data -> 0x00000080.
- LW addr=0x3002 -> no mem_req; out_fault pulses 1 cycle; out_RegWrite=0.
- Reset asserted on the 2nd wait cycle of an LW -> next cycle mem_req=0, stall=0, all outputs 0.
- Back-to-back SW 0x4000 then LW 0x4000, zero-wait memory -> two requests on consecutive cycles; load returns the stored word; no stall.

Source files
------------

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
//
// This is the memory stage of a 5-stage RV32I pipeline. It holds the EX/MEM
// pipeline register and performs byte, halfword and word accesses over a
// req/ready data-memory handshake. Results are registered into the MEM/WB
// register.
//
// Parameters
//   ADDR_W          byte-address width of mem_addr (at most 32)
//   FAULT_SUPPRESS  1: a faulting op issues no request and drops its RegWrite
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_*                      execute-stage outputs (held by upstream on stall)
//   stall                     freeze upstream stages while an access waits
//   mem_req/we/addr/wdata/wstrb
//                             request side of the data-memory handshake
//   mem_ready/rdata           completion and aligned read word
//   ex_mem_*                  forwarding bus back to execute (from the latch)
//   out_*                     MEM/WB register; out_fault is a one-cycle pulse
// -----------------------------------------------------------------------------
module memory_access #(
  parameter int ADDR_W         = 32,
  parameter bit FAULT_SUPPRESS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_MemRead,
  input  logic              in_MemWrite,
  input  logic              in_RegWrite,
  input  logic [4:0]        in_RegDest,
  input  logic              in_MemToReg,
  input  logic [2:0]        in_Funct3,
  input  logic [31:0]       in_AluResult,
  input  logic [31:0]       in_rs2_value,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              ex_mem_RegWrite,
  output logic [4:0]        ex_mem_RegDest,
  output logic [31:0]       ex_mem_result,
  output logic              out_RegWrite,
  output logic [4:0]        out_RegDest,
  output logic              out_MemToReg,
  output logic [31:0]       out_AluResult,
  output logic [31:0]       out_data,
  output logic              out_fault
);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [4:0]  reg_dest;
    logic        mem_to_reg;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] rs2_value;
  } ex_mem_t;

  // Misalignment or an funct3 that this access type does not support.
  function automatic logic calc_fault(input logic rd, input logic wr,
                                      input logic [2:0] f3, input logic [1:0] a);
    logic f;
    f = 1'b0;
    if (rd) begin
      case (f3)
        3'b000, 3'b100: f = 1'b0;
        3'b001, 3'b101: f = a[0];
        3'b010:         f = (a != 2'b00);
        default:        f = 1'b1;
      endcase
    end else if (wr) begin
      case (f3)
        3'b000:  f = 1'b0;
        3'b001:  f = a[0];
        3'b010:  f = (a != 2'b00);
        default: f = 1'b1;
      endcase
    end
    return f;
  endfunction

  state_t     state;
  ex_mem_t    lat;
  ex_mem_t    nxt;
  logic       fault;
  logic       nxt_fault;
  logic       nxt_access;
  logic [1:0] ofs;
  logic [31:0] load_data;
  logic [31:0] byte_word;

  assign nxt = '{mem_read:   in_MemRead,
                 mem_write:  in_MemWrite,
                 reg_write:  in_RegWrite,
                 reg_dest:   in_RegDest,
                 mem_to_reg: in_MemToReg,
                 funct3:     in_Funct3,
                 alu_result: in_AluResult,
                 rs2_value:  in_rs2_value};

  assign ofs   = lat.alu_result[1:0];
  assign fault = calc_fault(lat.mem_read, lat.mem_write, lat.funct3, ofs);

  // The state after a latch load is decided by the op being latched, so an
  // access can follow an access with no idle cycle in between.
  assign nxt_fault  = calc_fault(in_MemRead, in_MemWrite, in_Funct3, in_AluResult[1:0]);
  assign nxt_access = (in_MemRead | in_MemWrite) & ~(nxt_fault & FAULT_SUPPRESS);

  // Memory-side handshake; a zero-wait access (mem_ready in the first ACCESS
  // cycle) never raises stall.
  assign mem_req  = (state == ACCESS);
  assign mem_we   = (state == ACCESS) & lat.mem_write;
  assign stall    = (state == ACCESS) & ~mem_ready;
  assign mem_addr = {lat.alu_result[ADDR_W-1:2], 2'b00};

  // Forwarding bus straight from the latch, so it stays valid while stalled.
  assign ex_mem_RegWrite = lat.reg_write;
  assign ex_mem_RegDest  = lat.reg_dest;
  assign ex_mem_result   = lat.alu_result;

  // Store lane placement. The latch only changes when stall is low, so these
  // stay stable for the whole access.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned and infers a latch.
    mem_wdata = lat.rs2_value;
    mem_wstrb = 4'b0000;
    case (lat.funct3)
      3'b000:  mem_wdata = {4{lat.rs2_value[7:0]}};
      3'b001:  mem_wdata = {2{lat.rs2_value[15:0]}};
      default: mem_wdata = lat.rs2_value;
    endcase
    if (lat.mem_write) begin
      case (lat.funct3)
        3'b000:  mem_wstrb = 4'b0001 << ofs;
        3'b001:  mem_wstrb = 4'b0011 << ofs;
        3'b010:  mem_wstrb = 4'b1111;
        default: mem_wstrb = 4'b0000;
      endcase
    end
  end

  // Load extraction. It is only meaningful when an access really returned data.
  // A load that faulted without an access writes back zero.
  assign byte_word = mem_rdata >> {ofs, 3'b000};

  always_comb begin
    load_data = 32'h0;
    if (lat.mem_read && state == ACCESS) begin
      case (lat.funct3)
        3'b000:  load_data = {{24{byte_word[7]}}, byte_word[7:0]};
        3'b100:  load_data = {24'h0, byte_word[7:0]};
        3'b001:  load_data = ofs[1] ? {{16{mem_rdata[31]}}, mem_rdata[31:16]}
                                    : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
        3'b101:  load_data = ofs[1] ? {16'h0, mem_rdata[31:16]}
                                    : {16'h0, mem_rdata[15:0]};
        3'b010:  load_data = mem_rdata;
        default: load_data = 32'h0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lat           <= '0;
      out_RegWrite  <= 1'b0;
      out_RegDest   <= 5'd0;
      out_MemToReg  <= 1'b0;
      out_AluResult <= 32'h0;
      out_data      <= 32'h0;
      out_fault     <= 1'b0;
    end else if (!stall) begin
      lat           <= nxt;
      state         <= nxt_access ? ACCESS : IDLE;
      out_RegWrite  <= lat.reg_write & ~(fault & FAULT_SUPPRESS);
      out_RegDest   <= lat.reg_dest;
      out_MemToReg  <= lat.mem_to_reg;
      out_AluResult <= lat.alu_result;
      out_data      <= load_data;
      out_fault     <= fault;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// -----------------------------------------------------------------------------
// tb_memory_access
//
// Directed testbench for memory_access. A driver issues ops and pushes the
// expected MEM/WB and memory-request records into queues. A separate
// monitor/responder models the data memory and pops and compares the records
// whenever the DUT presents a request or a non-bubble MEM/WB result.
// -----------------------------------------------------------------------------
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_MemRead, in_MemWrite, in_RegWrite, in_MemToReg;
  logic [4:0]  in_RegDest;
  logic [2:0]  in_Funct3;
  logic [31:0] in_AluResult, in_rs2_value;
  logic        stall, mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        ex_mem_RegWrite;
  logic [4:0]  ex_mem_RegDest;
  logic [31:0] ex_mem_result;
  logic        out_RegWrite, out_MemToReg, out_fault;
  logic [4:0]  out_RegDest;
  logic [31:0] out_AluResult, out_data;

  always #5 clk = ~clk;

  memory_access #(.ADDR_W(32), .FAULT_SUPPRESS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite), .in_RegWrite(in_RegWrite),
    .in_RegDest(in_RegDest), .in_MemToReg(in_MemToReg), .in_Funct3(in_Funct3),
    .in_AluResult(in_AluResult), .in_rs2_value(in_rs2_value),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .ex_mem_RegWrite(ex_mem_RegWrite), .ex_mem_RegDest(ex_mem_RegDest),
    .ex_mem_result(ex_mem_result),
    .out_RegWrite(out_RegWrite), .out_RegDest(out_RegDest), .out_MemToReg(out_MemToReg),
    .out_AluResult(out_AluResult), .out_data(out_data), .out_fault(out_fault)
  );

  typedef struct {
    logic rd_op; logic wr_op; logic rw; logic [4:0] rdst; logic m2r;
    logic [2:0] f3; logic [31:0] alu; logic [31:0] rs2;
  } op_t;
  typedef struct {
    logic rw; logic [4:0] rd; logic m2r; logic [31:0] alu; logic [31:0] data; logic fault;
  } wb_t;
  typedef struct {
    logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; int waits; bit abort;
  } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  logic [31:0] mem_model [logic [31:0]];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int req_start_prev = -10;
  int req_start_last = -10;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ctrl"}, 32'({mem_req, mem_we, stall, ex_mem_RegWrite,
                              out_RegWrite, out_MemToReg, out_fault}), 32'h0);
    check({tag, "_mem_addr"},  mem_addr, 32'h0);
    check({tag, "_wdata"},     mem_wdata, 32'h0);
    check({tag, "_wstrb"},     32'(mem_wstrb), 32'h0);
    check({tag, "_dests"},     32'({ex_mem_RegDest, out_RegDest}), 32'h0);
    check({tag, "_ex_result"}, ex_mem_result, 32'h0);
    check({tag, "_out_alu"},   out_AluResult, 32'h0);
    check({tag, "_out_data"},  out_data, 32'h0);
  endtask

  // Memory responder and MEM/WB monitor, evaluated on the falling edge.
  initial begin : monitor
    bit   upd;
    bit   active;
    req_t cur;
    wb_t  e;
    int   waits_left;
    int   stall_cnt;
    logic [31:0] w;
    upd = 0; active = 0; waits_left = 0; stall_cnt = 0;
    cur = '{1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0};
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (upd && (out_RegWrite || out_MemToReg || out_fault || out_RegDest != 0 ||
                  out_AluResult != 0 || out_data != 0)) begin
        if (wb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL wb_unexpected: got MEM/WB alu 0x%08h, expected no result", out_AluResult);
        end else begin
          e = wb_q.pop_front();
          check("out_RegWrite",  32'(out_RegWrite), 32'(e.rw));
          check("out_RegDest",   32'(out_RegDest),  32'(e.rd));
          check("out_MemToReg",  32'(out_MemToReg), 32'(e.m2r));
          check("out_AluResult", out_AluResult, e.alu);
          check("out_data",      out_data, e.data);
          check("out_fault",     32'(out_fault), 32'(e.fault));
        end
      end
      if (rst) begin
        active = 0;
        mem_ready = 1'b0;
      end else if (mem_req) begin
        if (!active) begin
          if (req_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL req_unexpected: got request to 0x%08h, expected none", mem_addr);
            cur = '{mem_we, mem_addr, mem_wdata, mem_wstrb, 0, 1'b1};
          end else begin
            cur = req_q.pop_front();
            check("mem_we",    32'(mem_we), 32'(cur.we));
            check("mem_addr",  mem_addr, cur.addr);
            check("mem_wdata", mem_wdata, cur.wdata);
            check("mem_wstrb", 32'(mem_wstrb), 32'(cur.strb));
          end
          active = 1; waits_left = cur.waits; stall_cnt = 0;
          req_start_prev = req_start_last;
          req_start_last = cyc;
        end else begin
          check("mem_addr_stable", mem_addr, cur.addr);
        end
        if (waits_left == 0) begin
          w = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
          mem_rdata = w;
          if (mem_we) begin
            for (int i = 0; i < 4; i++)
              if (mem_wstrb[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
            mem_model[mem_addr] = w;
          end
          mem_ready = 1'b1;
        end else begin
          mem_ready = 1'b0;
          waits_left--;
        end
      end else begin
        mem_ready = 1'b0;
      end
      #1;
      if (active) begin
        if (stall) stall_cnt++;
        if (mem_ready) begin
          active = 0;
          if (!cur.abort) check("stall_cycles", 32'(stall_cnt), 32'(cur.waits));
        end
      end
      upd = !stall && !rst;
    end
  end

  task automatic drive(input op_t op);
    in_MemRead   = op.rd_op;
    in_MemWrite  = op.wr_op;
    in_RegWrite  = op.rw;
    in_RegDest   = op.rdst;
    in_MemToReg  = op.m2r;
    in_Funct3    = op.f3;
    in_AluResult = op.alu;
    in_rs2_value = op.rs2;
  endtask

  // Called at posedge+2. Holds the op until it is accepted, then leaves a
  // bubble on the inputs.
  task automatic issue(input op_t op, input bit has_req, input req_t r, input wb_t w);
    int n;
    drive(op);
    wb_q.push_back(w);
    if (has_req) req_q.push_back(r);
    n = 0;
    do begin
      @(negedge clk); #2; n++;
    end while (stall && n < 40);
    if (stall) begin
      tests++; fails++;
      $display("FAIL issue_timeout: stall still 1 after %0d cycles, expected 0", n);
    end
    @(posedge clk); #1;
    check("ex_mem_RegWrite", 32'(ex_mem_RegWrite), 32'(op.rw));
    check("ex_mem_RegDest",  32'(ex_mem_RegDest),  32'(op.rdst));
    check("ex_mem_result",   ex_mem_result, op.alu);
    #1;
    drive('{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 32'h0});
  endtask

  localparam req_t NOREQ = '{1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0};

  initial begin : driver
    rst = 1'b1;
    drive('{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 32'h0});
    mem_model[32'h2000] = 32'h0000_80FF;
    repeat (2) @(posedge clk);
    #1 check_reset_state("reset");
    #1 rst = 1'b0;

    // ALU op: rd=5, 0x1234, no request.
    issue('{0,0,1, 5'd5, 0, 3'b000, 32'h1234, 32'h0}, 0, NOREQ,
          '{1, 5'd5, 0, 32'h1234, 32'h0, 0});
    // SB to byte 3.
    issue('{0,1,0, 5'd0, 0, 3'b000, 32'h1003, 32'hAABBCCDD}, 1,
          '{1, 32'h1000, 32'hDDDDDDDD, 4'b1000, 0, 0},
          '{0, 5'd0, 0, 32'h1003, 32'h0, 0});
    // LB byte 1 of 0x000080FF with 3 wait cycles, then LBU zero-wait.
    issue('{1,0,1, 5'd7, 1, 3'b000, 32'h2001, 32'h0}, 1,
          '{0, 32'h2000, 32'h0, 4'b0000, 3, 0},
          '{1, 5'd7, 1, 32'h2001, 32'hFFFFFF80, 0});
    issue('{1,0,1, 5'd8, 1, 3'b100, 32'h2001, 32'h0}, 1,
          '{0, 32'h2000, 32'h0, 4'b0000, 0, 0},
          '{1, 5'd8, 1, 32'h2001, 32'h00000080, 0});
    // Misaligned LW: no request, fault, RegWrite suppressed; next op clears fault.
    issue('{1,0,1, 5'd9, 1, 3'b010, 32'h3002, 32'h0}, 0, NOREQ,
          '{0, 5'd9, 1, 32'h3002, 32'h0, 1});
    issue('{0,0,1, 5'd10, 0, 3'b000, 32'hCAFEF00D, 32'h0}, 0, NOREQ,
          '{1, 5'd10, 0, 32'hCAFEF00D, 32'h0, 0});
    // SH to upper half with one wait, then read back as LH/LHU/LW.
    issue('{0,1,0, 5'd0, 0, 3'b001, 32'h1002, 32'h1234BEEF}, 1,
          '{1, 32'h1000, 32'hBEEFBEEF, 4'b1100, 1, 0},
          '{0, 5'd0, 0, 32'h1002, 32'h0, 0});
    issue('{1,0,1, 5'd11, 1, 3'b001, 32'h1002, 32'h0}, 1,
          '{0, 32'h1000, 32'h0, 4'b0000, 2, 0},
          '{1, 5'd11, 1, 32'h1002, 32'hFFFFBEEF, 0});
    issue('{1,0,1, 5'd12, 1, 3'b101, 32'h1002, 32'h0}, 1,
          '{0, 32'h1000, 32'h0, 4'b0000, 0, 0},
          '{1, 5'd12, 1, 32'h1002, 32'h0000BEEF, 0});
    issue('{1,0,1, 5'd13, 1, 3'b010, 32'h1000, 32'h0}, 1,
          '{0, 32'h1000, 32'h0, 4'b0000, 0, 0},
          '{1, 5'd13, 1, 32'h1000, 32'hBEEF0000, 0});
    // Illegal load funct3 and misaligned SH: both fault with no request.
    issue('{1,0,1, 5'd14, 1, 3'b011, 32'h5000, 32'h0}, 0, NOREQ,
          '{0, 5'd14, 1, 32'h5000, 32'h0, 1});
    issue('{0,1,0, 5'd0, 0, 3'b001, 32'h1001, 32'h1}, 0, NOREQ,
          '{0, 5'd0, 0, 32'h1001, 32'h0, 1});
    // Back-to-back SW then LW, zero-wait.
    issue('{0,1,0, 5'd0, 0, 3'b010, 32'h4000, 32'h13579BDF}, 1,
          '{1, 32'h4000, 32'h13579BDF, 4'b1111, 0, 0},
          '{0, 5'd0, 0, 32'h4000, 32'h0, 0});
    issue('{1,0,1, 5'd15, 1, 3'b010, 32'h4000, 32'h0}, 1,
          '{0, 32'h4000, 32'h0, 4'b0000, 0, 0},
          '{1, 5'd15, 1, 32'h4000, 32'h13579BDF, 0});
    @(negedge clk); #2;
    check("b2b_req_spacing", 32'(req_start_last - req_start_prev), 32'd1);
    @(posedge clk); #2;

    // Reset asserted during the 2nd wait cycle of an LW.
    drive('{1,0,1, 5'd3, 1, 3'b010, 32'h6000, 32'h0});
    req_q.push_back('{0, 32'h6000, 32'h0, 4'b0000, 10, 1});
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    drive('{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 32'h0});
    @(posedge clk);
    #1 check_reset_state("abort");
    #1 rst = 1'b0;

    // Recovery after reset.
    issue('{0,0,1, 5'd1, 0, 3'b000, 32'h55, 32'h0}, 0, NOREQ,
          '{1, 5'd1, 0, 32'h55, 32'h0, 0});
    repeat (4) @(posedge clk);
    #2;
    check("wb_queue_drained",  32'(wb_q.size()), 32'd0);
    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
